// File: rtl/csr_exec_unit_if.sv
// CSR request/response bundle between the EX stage (master) and the CSR unit (slave).
// Outputs are combinational from the request, so both sides see them in the same cycle.
interface csr_exec_unit_if;
  logic        is_csr;
  logic        csr_write_en;
  logic [2:0]  func3;
  logic [4:0]  zimm;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata;
  logic        csr_illegal;

  modport master (
    output is_csr, csr_write_en, func3, zimm, csr_addr, rs1_data,
    input  csr_rdata, csr_wdata, csr_illegal
  );

  modport slave (
    input  is_csr, csr_write_en, func3, zimm, csr_addr, rs1_data,
    output csr_rdata, csr_wdata, csr_illegal
  );
endinterface

// File: rtl/csr_exec_unit.sv
// CSR execute unit: 16-entry scratch bank plus 64-bit mcycle/minstret counters.
// Read/modify results are combinational; commits land on the next rising edge.
module csr_exec_unit (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubbleE,
  input  logic            flushE,
  input  logic            instr_retire,
  csr_exec_unit_if.slave  csr
);

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_BANK,
    TGT_MCYCLE_LO,
    TGT_MCYCLE_HI,
    TGT_MINSTRET_LO,
    TGT_MINSTRET_HI
  } csr_target_e;

  localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;

  logic [31:0] bank [16];
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [63:0] mcycle_next;
  logic [63:0] minstret_next;

  csr_target_e target;
  logic [31:0] old_val;
  logic [31:0] operand;
  logic [31:0] new_val;
  logic        func_ok;
  logic        illegal;
  logic        commit;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    target = TGT_NONE;
    if (csr.csr_addr[11:4] == 8'h30) begin
      target = TGT_BANK;
    end else begin
      case (csr.csr_addr)
        ADDR_MCYCLE:    target = TGT_MCYCLE_LO;
        ADDR_MCYCLEH:   target = TGT_MCYCLE_HI;
        ADDR_MINSTRET:  target = TGT_MINSTRET_LO;
        ADDR_MINSTRETH: target = TGT_MINSTRET_HI;
        default:        target = TGT_NONE;
      endcase
    end
  end

  always_comb begin
    old_val = '0;
    unique case (target)
      TGT_BANK:        old_val = bank[csr.csr_addr[3:0]];
      TGT_MCYCLE_LO:   old_val = mcycle[31:0];
      TGT_MCYCLE_HI:   old_val = mcycle[63:32];
      TGT_MINSTRET_LO: old_val = minstret[31:0];
      TGT_MINSTRET_HI: old_val = minstret[63:32];
      default:         old_val = '0;
    endcase
  end

  assign operand = csr.func3[2] ? {27'b0, csr.zimm} : csr.rs1_data;

  // func3[1:0]==00 has no defined operation: pass the old value through and flag it.
  always_comb begin
    new_val = old_val;
    func_ok = 1'b1;
    case (csr.func3[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: func_ok = 1'b0;
    endcase
  end

  assign illegal = csr.is_csr & ((target == TGT_NONE) | ~func_ok);
  assign commit  = csr.is_csr & csr.csr_write_en & ~bubbleE & ~flushE & ~illegal;

  assign csr.csr_rdata   = csr.is_csr ? old_val : '0;
  assign csr.csr_wdata   = csr.is_csr ? new_val : '0;
  assign csr.csr_illegal = illegal;

  // A write to either half freezes the whole counter for that cycle (no carry, no increment).
  always_comb begin
    mcycle_next = mcycle + 64'd1;
    if (commit && target == TGT_MCYCLE_LO) begin
      mcycle_next = {mcycle[63:32], new_val};
    end else if (commit && target == TGT_MCYCLE_HI) begin
      mcycle_next = {new_val, mcycle[31:0]};
    end
  end

  always_comb begin
    minstret_next = minstret + {63'd0, instr_retire};
    if (commit && target == TGT_MINSTRET_LO) begin
      minstret_next = {minstret[63:32], new_val};
    end else if (commit && target == TGT_MINSTRET_HI) begin
      minstret_next = {new_val, minstret[31:0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
    end
  end

  // NOTE: the bank must read 0 after reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        bank[i] <= '0;
      end
    end else if (commit && target == TGT_BANK) begin
      bank[csr.csr_addr[3:0]] <= new_val;
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: bank read-modify-write, counter carry/priority,
// stall/flush gating, illegal accesses and mid-sequence reset.
module tb_csr_exec_unit;

  logic clk;
  logic rst;
  logic bubbleE;
  logic flushE;
  logic instr_retire;

  int n_checks = 0;
  int n_errors = 0;

  csr_exec_unit_if csr_if ();

  csr_exec_unit dut (
    .clk          (clk),
    .rst          (rst),
    .bubbleE      (bubbleE),
    .flushE       (flushE),
    .instr_retire (instr_retire),
    .csr          (csr_if.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    csr_if.is_csr       = 1'b0;
    csr_if.csr_write_en = 1'b0;
    csr_if.func3        = 3'b000;
    csr_if.zimm         = 5'd0;
    csr_if.csr_addr     = 12'h000;
    csr_if.rs1_data     = 32'h0;
    bubbleE             = 1'b0;
    flushE              = 1'b0;
    instr_retire        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  // Pure read (CSRRS with rs1=0, no write enable); does not advance the clock.
  task automatic peek(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    csr_if.is_csr       = 1'b1;
    csr_if.csr_write_en = 1'b0;
    csr_if.func3        = 3'b010;
    csr_if.rs1_data     = 32'h0;
    csr_if.zimm         = 5'd0;
    csr_if.csr_addr     = addr;
    #1;
    check(tag, csr_if.csr_rdata, exp);
  endtask

  task automatic exec(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                      input logic [4:0] zi, input logic we, input logic chk_rd,
                      input logic [31:0] exp_rd, input logic [31:0] exp_wd,
                      input logic exp_ill, input string tag);
    csr_if.is_csr       = 1'b1;
    csr_if.csr_write_en = we;
    csr_if.func3        = f3;
    csr_if.csr_addr     = addr;
    csr_if.rs1_data     = rs1;
    csr_if.zimm         = zi;
    #1;
    if (chk_rd) check({tag, "_rdata"}, csr_if.csr_rdata, exp_rd);
    check({tag, "_wdata"}, csr_if.csr_wdata, exp_wd);
    check({tag, "_illegal"}, {31'd0, csr_if.csr_illegal}, {31'd0, exp_ill});
    step();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Outputs are forced to 0 when is_csr is low, even for an unmapped write.
    csr_if.is_csr       = 1'b0;
    csr_if.csr_write_en = 1'b1;
    csr_if.func3        = 3'b001;
    csr_if.csr_addr     = 12'h7C0;
    csr_if.rs1_data     = 32'hFFFF_FFFF;
    #1;
    check("nocsr_rdata", csr_if.csr_rdata, 32'h0);
    check("nocsr_wdata", csr_if.csr_wdata, 32'h0);
    check("nocsr_illegal", {31'd0, csr_if.csr_illegal}, 32'h0);
    idle();

    peek(12'hB00, 32'h0, "rst_mcycle_lo");
    peek(12'hB80, 32'h0, "rst_mcycle_hi");
    peek(12'hB02, 32'h0, "rst_minstret_lo");
    peek(12'h305, 32'h0, "rst_bank305");
    step();
    peek(12'hB00, 32'h1, "mcycle_first_edge");

    // Read-modify-write on the bank, back to back.
    exec(3'b001, 12'h305, 32'hDEAD_0000, 5'd0, 1'b1, 1'b1, 32'h0, 32'hDEAD_0000, 1'b0, "rw305");
    exec(3'b010, 12'h305, 32'h0000_BEEF, 5'd0, 1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, "rs305");
    peek(12'h305, 32'hDEAD_BEEF, "bank305_rs");
    exec(3'b111, 12'h305, 32'hFFFF_FFFF, 5'h0F, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEE0, 1'b0, "rci305");
    peek(12'h305, 32'hDEAD_BEE0, "bank305_rci");
    exec(3'b110, 12'h30F, 32'hFFFF_FFFF, 5'h15, 1'b1, 1'b1, 32'h0, 32'h15, 1'b0, "rsi30f");
    peek(12'h30F, 32'h15, "bank30f");
    peek(12'h300, 32'h0, "bank300_untouched");

    // Stall / flush gating.
    bubbleE = 1'b1;
    exec(3'b001, 12'h300, 32'h1234, 5'd0, 1'b1, 1'b1, 32'h0, 32'h1234, 1'b0, "rw300_bubble");
    flushE = 1'b1;
    exec(3'b001, 12'h300, 32'h1234, 5'd0, 1'b1, 1'b1, 32'h0, 32'h1234, 1'b0, "rw300_flush");
    bubbleE = 1'b1;
    flushE  = 1'b1;
    exec(3'b001, 12'h300, 32'h1234, 5'd0, 1'b1, 1'b1, 32'h0, 32'h1234, 1'b0, "rw300_both");
    peek(12'h300, 32'h0, "bank300_gated");

    exec(3'b010, 12'h305, 32'h0000_00FF, 5'd0, 1'b0, 1'b1, 32'hDEAD_BEE0, 32'hDEAD_BEFF, 1'b0, "rs305_nowe");
    peek(12'h305, 32'hDEAD_BEE0, "bank305_nowe");

    // mcycle carry from low to high half; counters run through bubble+flush.
    exec(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, "rw_mcycle");
    peek(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_written");
    peek(12'hB80, 32'h0, "mcycle_hi_before_carry");
    bubbleE = 1'b1;
    flushE  = 1'b1;
    step();
    peek(12'hB00, 32'h0, "mcycle_lo_wrap");
    peek(12'hB80, 32'h1, "mcycle_hi_carry");
    bubbleE = 1'b1;
    flushE  = 1'b1;
    step();
    peek(12'hB00, 32'h1, "mcycle_lo_after2");
    peek(12'hB80, 32'h1, "mcycle_hi_after2");

    // Writing the high half freezes the low half for that cycle.
    exec(3'b001, 12'hB80, 32'hA, 5'd0, 1'b1, 1'b1, 32'h1, 32'hA, 1'b0, "rw_mcycleh");
    peek(12'hB00, 32'h1, "mcycle_lo_held");
    peek(12'hB80, 32'hA, "mcycle_hi_written");

    // minstret: write beats retire, then increments and carry.
    instr_retire = 1'b1;
    exec(3'b001, 12'hB02, 32'h5, 5'd0, 1'b1, 1'b1, 32'h0, 32'h5, 1'b0, "rw_minstret");
    peek(12'hB02, 32'h5, "minstret_write_wins");
    instr_retire = 1'b1;
    step();
    peek(12'hB02, 32'h6, "minstret_retire");
    exec(3'b001, 12'hB02, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b1, 32'h6, 32'hFFFF_FFFF, 1'b0, "rw_minstret_max");
    instr_retire = 1'b1;
    step();
    peek(12'hB02, 32'h0, "minstret_lo_wrap");
    peek(12'hB82, 32'h1, "minstret_hi_carry");
    step();
    peek(12'hB02, 32'h0, "minstret_hold_noretire");

    // Illegal accesses change nothing.
    exec(3'b001, 12'h301, 32'hA5, 5'd0, 1'b1, 1'b1, 32'h0, 32'hA5, 1'b0, "rw301");
    peek(12'h301, 32'hA5, "bank301");
    exec(3'b001, 12'h7C0, 32'hFFFF, 5'd0, 1'b1, 1'b1, 32'h0, 32'hFFFF, 1'b1, "rw7c0");
    exec(3'b000, 12'h301, 32'h55, 5'd0, 1'b1, 1'b1, 32'hA5, 32'hA5, 1'b1, "f000_301");
    exec(3'b100, 12'h301, 32'h0, 5'h1F, 1'b1, 1'b1, 32'hA5, 32'hA5, 1'b1, "f100_301");
    peek(12'h301, 32'hA5, "bank301_after_illegal");
    peek(12'h300, 32'h0, "bank300_after_illegal");
    peek(12'h305, 32'hDEAD_BEE0, "bank305_after_illegal");
    peek(12'hB82, 32'h1, "minstret_hi_after_illegal");

    // Reset in the same cycle as a write discards it.
    rst                 = 1'b1;
    csr_if.is_csr       = 1'b1;
    csr_if.csr_write_en = 1'b1;
    csr_if.func3        = 3'b001;
    csr_if.csr_addr     = 12'h305;
    csr_if.rs1_data     = 32'h1111;
    instr_retire        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    peek(12'h305, 32'h0, "rst2_bank305");
    peek(12'h301, 32'h0, "rst2_bank301");
    peek(12'h30F, 32'h0, "rst2_bank30f");
    peek(12'hB00, 32'h0, "rst2_mcycle_lo");
    peek(12'hB80, 32'h0, "rst2_mcycle_hi");
    peek(12'hB02, 32'h0, "rst2_minstret_lo");
    peek(12'hB82, 32'h0, "rst2_minstret_hi");
    step();
    peek(12'hB00, 32'h1, "rst2_mcycle_first_edge");
    peek(12'h305, 32'h0, "rst2_bank305_later");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
